// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and helpers for the program-counter generator
//
// Contents:
//   state_e    fetch control FSM states (IDLE / RUN / HALT)
//   sel_e      next-PC source select codes for the priority mux
//   ptr_bits   pointer width for a power-of-two deep structure (minimum 1 bit)
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_SEQ  = 3'd1,
    SEL_EXC  = 3'd2,
    SEL_BR   = 3'd3,
    SEL_RAS  = 3'd4,
    SEL_JMP  = 3'd5
  } sel_e;

  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch control / redirect bundle between the pipeline and pc_gen
//
// Signals:
//   start_i, halt_i, stall_i, exc_i       run control and hazard/exception inputs
//   br_taken_i, br_target_i               taken-branch redirect
//   jmp_i, jmp_target_i, call_i, ret_i    jump / call / return redirect
//   pc_o, pc_valid_o                      registered fetch address and its valid
//   ras_empty_o, ras_full_o, ras_uflow_o  return-address-stack status
// Modports: master drives the control inputs, slave is the pc_gen side.
interface pc_gen_if #(
  parameter int PC_WIDTH = 32
);
  logic                start_i;
  logic                halt_i;
  logic                stall_i;
  logic                exc_i;
  logic                br_taken_i;
  logic [PC_WIDTH-1:0] br_target_i;
  logic                jmp_i;
  logic [PC_WIDTH-1:0] jmp_target_i;
  logic                call_i;
  logic                ret_i;
  logic [PC_WIDTH-1:0] pc_o;
  logic                pc_valid_o;
  logic                ras_empty_o;
  logic                ras_full_o;
  logic                ras_uflow_o;

  modport master (
    output start_i, halt_i, stall_i, exc_i, br_taken_i, br_target_i,
           jmp_i, jmp_target_i, call_i, ret_i,
    input  pc_o, pc_valid_o, ras_empty_o, ras_full_o, ras_uflow_o
  );

  modport slave (
    input  start_i, halt_i, stall_i, exc_i, br_taken_i, br_target_i,
           jmp_i, jmp_target_i, call_i, ret_i,
    output pc_o, pc_valid_o, ras_empty_o, ras_full_o, ras_uflow_o
  );
endinterface

// File: rtl/pc_gen_ras.sv
// rtl/pc_gen_ras.sv - circular return-address stack with push/pop/flush
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  push a return address (overwrites the oldest entry when full)
//   pop_i           discard the top entry (ignored when empty)
//   flush_i         drop all entries; wins over push/pop
//   top_o           current top entry (meaningful only when not empty)
//   empty_o, full_o occupancy flags
module pc_gen_ras
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = ptr_bits(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]    top_q;
  logic [PW:0]      cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr;

  assign wr_ptr  = top_q + 1'b1;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign top_o   = mem_q[top_q];

  // The pointer wraps freely: when full, the slot after top is the oldest
  // entry, so a push simply overwrites it while the count saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (push_i) begin
      top_q <= wr_ptr;
      if (!full_o) cnt_q <= cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      top_q <= top_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program-counter generator with start/halt FSM and RAS
//
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_i   asynchronous active-low reset
//   bus     pc_gen_if.slave: run control, redirects, pc_o/pc_valid_o, RAS status
// Next-PC priority in RUN: exception, halt, hold (stall or !start), branch,
// return, jump, sequential.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                   PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VEC   = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0]  EXC_VEC     = 32'h0000_0100,
  parameter int                   INSTR_BYTES = 4,
  parameter int                   RAS_DEPTH   = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  pc_gen_if.slave bus
);

  localparam logic [PC_WIDTH-1:0] INCR       = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(INSTR_BYTES - 1));

  state_e              state_q, state_d;
  sel_e                sel;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic                valid_q, uflow_q, uflow_d, start_q;
  logic                ras_push, ras_pop, ras_flush;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_empty, ras_full;

  assign pc_inc = pc_q + INCR;

  pc_gen_ras #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .flush_i (ras_flush),
    .data_i  (pc_inc),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

  always_comb begin
    state_d   = state_q;
    sel       = SEL_HOLD;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_flush = 1'b0;
    uflow_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.exc_i) begin
          sel       = SEL_EXC;
          ras_flush = 1'b1;
        end else if (bus.halt_i) begin
          state_d = ST_HALT;
        end else if (!bus.start_i || bus.stall_i) begin
          sel = SEL_HOLD;
        end else if (bus.br_taken_i) begin
          sel = SEL_BR;
        end else if (bus.ret_i) begin
          // An empty stack falls back to the jump target and flags it.
          if (ras_empty) begin
            sel     = SEL_JMP;
            uflow_d = 1'b1;
          end else begin
            sel     = SEL_RAS;
            ras_pop = 1'b1;
          end
        end else if (bus.jmp_i) begin
          sel      = SEL_JMP;
          ras_push = bus.call_i;
        end else begin
          sel = SEL_SEQ;
        end
      end
      ST_HALT: begin
        if (bus.exc_i) begin
          state_d   = ST_RUN;
          sel       = SEL_EXC;
          ras_flush = 1'b1;
        end else if (bus.start_i && !start_q) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      SEL_SEQ: pc_d = pc_inc;
      SEL_EXC: pc_d = EXC_VEC;
      SEL_BR:  pc_d = bus.br_target_i & ALIGN_MASK;
      SEL_RAS: pc_d = ras_top;
      SEL_JMP: pc_d = bus.jmp_target_i & ALIGN_MASK;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      uflow_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= (state_d == ST_RUN) && bus.start_i;
      uflow_q <= uflow_d;
      start_q <= bus.start_i;
    end
  end

  assign bus.pc_o        = pc_q;
  assign bus.pc_valid_o  = valid_q;
  assign bus.ras_empty_o = ras_empty;
  assign bus.ras_full_o  = ras_full;
  assign bus.ras_uflow_o = uflow_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen against a queue-based reference model
module tb_pc_gen;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0100;
  localparam int          DEPTH     = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        empty;
    logic        full;
    logic        uflow;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  pc_gen_if #(.PC_WIDTH(32)) bus();

  pc_gen #(
    .PC_WIDTH(32), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC),
    .INSTR_BYTES(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 run, 2 halt; RAS kept as a plain queue.
  int          m_state;
  logic [31:0] m_pc;
  bit          m_prev_start;
  bit          m_valid;
  bit          m_uflow;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = RESET_VEC; m_prev_start = 0; m_valid = 0; m_uflow = 0;
    m_ras.delete();
  endtask

  task automatic model_step(input bit s, h, st, e, br, input logic [31:0] bt,
                            input bit j, input logic [31:0] jt, input bit c, r);
    int ns = m_state;
    m_uflow = 0;
    if (m_state == 0) begin
      if (s) ns = 1;
    end else if (m_state == 1) begin
      if (e) begin
        m_pc = EXC_VEC; m_ras.delete();
      end else if (h) ns = 2;
      else if (!s || st) ;
      else if (br) m_pc = bt & ~32'h3;
      else if (r) begin
        if (m_ras.size() == 0) begin m_pc = jt & ~32'h3; m_uflow = 1; end
        else m_pc = m_ras.pop_back();
      end else if (j) begin
        if (c) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        m_pc = jt & ~32'h3;
      end else m_pc = m_pc + 32'd4;
    end else begin
      if (e) begin ns = 1; m_pc = EXC_VEC; m_ras.delete(); end
      else if (s && !m_prev_start) ns = 1;
    end
    m_prev_start = s;
    m_state = ns;
    m_valid = (ns == 1) && s;
  endtask

  task automatic drive(input bit s, h, st, e, br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input bit c, r);
    exp_t x;
    @(negedge clk);
    bus.start_i = s; bus.halt_i = h; bus.stall_i = st; bus.exc_i = e;
    bus.br_taken_i = br; bus.br_target_i = bt; bus.jmp_i = j; bus.jmp_target_i = jt;
    bus.call_i = c; bus.ret_i = r;
    model_step(s, h, st, e, br, bt, j, jt, c, r);
    x.pc = m_pc; x.valid = m_valid; x.uflow = m_uflow;
    x.empty = (m_ras.size() == 0); x.full = (m_ras.size() == DEPTH);
    exp_q.push_back(x);
  endtask

  task automatic idle_inputs();
    bus.start_i = 0; bus.halt_i = 0; bus.stall_i = 0; bus.exc_i = 0;
    bus.br_taken_i = 0; bus.br_target_i = '0; bus.jmp_i = 0; bus.jmp_target_i = '0;
    bus.call_i = 0; bus.ret_i = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    bus.pc_o, RESET_VEC);
    chk({tag, "_valid"}, {31'd0, bus.pc_valid_o}, 32'd0);
    chk({tag, "_empty"}, {31'd0, bus.ras_empty_o}, 32'd1);
    chk({tag, "_full"},  {31'd0, bus.ras_full_o}, 32'd0);
    chk({tag, "_uflow"}, {31'd0, bus.ras_uflow_o}, 32'd0);
  endtask

  // Monitor: one expectation per active edge, sampled 1 time unit after it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("pc",        bus.pc_o,                  x.pc);
        chk("pc_valid",  {31'd0, bus.pc_valid_o},   {31'd0, x.valid});
        chk("ras_empty", {31'd0, bus.ras_empty_o},  {31'd0, x.empty});
        chk("ras_full",  {31'd0, bus.ras_full_o},   {31'd0, x.full});
        chk("ras_uflow", {31'd0, bus.ras_uflow_o},  {31'd0, x.uflow});
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // start for several cycles: 0, 4, 8
    repeat (3) drive(1,0,0,0, 0,0, 0,0,0,0);
    // stall beats branch, then exception
    drive(1,0,1,0, 1,32'h40, 0,0,0,0);
    drive(1,0,1,1, 0,0, 0,0,0,0);
    // reach 0x10, call 0x200, step, return
    drive(1,0,0,0, 0,0, 1,32'h10,0,0);
    drive(1,0,0,0, 0,0, 1,32'h200,1,0);
    drive(1,0,0,0, 0,0, 0,0,0,0);
    drive(1,0,0,0, 0,0, 0,32'h0,0,1);
    // five calls overflow the stack, then five returns (last one underflows)
    for (int i = 0; i < 5; i++) drive(1,0,0,0, 0,0, 1,32'h1000*(i+1),1,0);
    for (int i = 0; i < 4; i++) drive(1,0,0,0, 0,0, 0,0,0,1);
    drive(1,0,0,0, 0,0, 0,32'h80,0,1);
    // losing sources: ret with branch, call without jmp
    drive(1,0,0,0, 0,0, 1,32'h300,1,0);
    drive(1,0,0,0, 1,32'h444, 0,0,0,1);
    drive(1,0,0,0, 0,0, 0,0,1,0);
    // halt at 0x20, then start falls and rises
    drive(1,0,0,0, 0,0, 1,32'h20,0,0);
    drive(1,1,0,0, 1,32'h500, 0,0,0,0);
    drive(1,0,0,0, 0,0, 0,0,0,0);
    drive(0,0,0,0, 0,0, 0,0,0,0);
    drive(1,0,0,0, 0,0, 0,0,0,0);
    drive(1,0,0,0, 0,0, 0,0,0,0);
    // exception while halted
    drive(1,0,0,0, 0,0, 1,32'h600,1,0);
    drive(1,1,0,0, 0,0, 0,0,0,0);
    drive(1,0,0,1, 0,0, 0,0,0,0);
    // wrap around the top of the address space, misaligned target
    drive(1,0,0,0, 0,0, 1,32'hFFFF_FFFF,0,0);
    drive(1,0,0,0, 0,0, 0,0,0,0);
    drive(1,0,0,0, 1,32'h0000_0703, 0,0,0,0);

    // reset asserted between edges while a branch is pending
    @(negedge clk);
    bus.br_taken_i = 1; bus.br_target_i = 32'h900;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_state("midreset");
    @(negedge clk);
    chk_reset_state("midreset_hold");
    idle_inputs();
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit s, h, st, e, br, j, c, r;
      logic [31:0] bt, jt;
      s  = ($urandom_range(0, 9) != 0);
      h  = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 4) == 0);
      e  = ($urandom_range(0, 39) == 0);
      br = ($urandom_range(0, 4) == 0);
      r  = ($urandom_range(0, 4) == 0);
      j  = ($urandom_range(0, 3) == 0);
      c  = $urandom_range(0, 1) == 1;
      bt = $urandom;
      jt = $urandom;
      drive(s, h, st, e, br, bt, j, jt, c, r);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
